// File: rtl/bitwise_logic_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bitwise_logic_pipe
// Brief    : Registered bitwise-op slice (NOT/AND/OR/XOR/NAND/NOR/XNOR/PASS)
//            feeding a 2-entry result queue with valid/ready handshakes on
//            both sides. The consumer may stall; in_ready depends only on
//            reset and the queue occupancy.
// Options  : BITWISE_LOGIC_PIPE_ZERO_FLAG_EN adds an out_zero port with a
//            per-entry (result == 0) flag that travels with each result.
// Revision : 1.0 - initial release
// ============================================================================
module bitwise_logic_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef BITWISE_LOGIC_PIPE_ZERO_FLAG_EN
    output logic             out_zero,
`endif
    output logic [WIDTH-1:0] out
);

    // Operation encodings
    localparam logic [2:0] c_OP_NOT  = 3'b000;
    localparam logic [2:0] c_OP_AND  = 3'b001;
    localparam logic [2:0] c_OP_OR   = 3'b010;
    localparam logic [2:0] c_OP_XOR  = 3'b011;
    localparam logic [2:0] c_OP_NAND = 3'b100;
    localparam logic [2:0] c_OP_NOR  = 3'b101;
    localparam logic [2:0] c_OP_XNOR = 3'b110;

    // Queue occupancy encodings (value 3 is unreachable)
    localparam logic [1:0] c_CNT_EMPTY = 2'd0;
    localparam logic [1:0] c_CNT_ONE   = 2'd1;
    localparam logic [1:0] c_CNT_FULL  = 2'd2;

    logic [1:0]       r_count;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [WIDTH-1:0] w_result;
    logic             w_accept;
    logic             w_pop;

    assign in_ready  = !reset && (r_count != c_CNT_FULL);
    assign out_valid = (r_count != c_CNT_EMPTY);
    assign out       = r_head;
    assign w_accept  = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Pure per-bit function of a, b and op; PASS is the fall-through case
    always_comb begin
        w_result = a;
        case (op)
            c_OP_NOT:  w_result = ~a;
            c_OP_AND:  w_result = a & b;
            c_OP_OR:   w_result = a | b;
            c_OP_XOR:  w_result = a ^ b;
            c_OP_NAND: w_result = ~(a & b);
            c_OP_NOR:  w_result = ~(a | b);
            c_OP_XNOR: w_result = ~(a ^ b);
            default:   w_result = a;
        endcase
    end

    // Two-entry FIFO: head is always the oldest result; tail only used when full.
    // State is written only on accept/pop, so X on idle inputs never lands here.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= c_CNT_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case (r_count)
                c_CNT_EMPTY: begin
                    if (w_accept) begin
                        r_head  <= w_result;
                        r_count <= c_CNT_ONE;
                    end
                end
                c_CNT_ONE: begin
                    if (w_accept && w_pop) begin
                        r_head <= w_result;
                    end else if (w_accept) begin
                        r_tail  <= w_result;
                        r_count <= c_CNT_FULL;
                    end else if (w_pop) begin
                        // head keeps its stale value; out_valid hides it
                        r_count <= c_CNT_EMPTY;
                    end
                end
                c_CNT_FULL: begin
                    if (w_pop) begin
                        r_head  <= r_tail;
                        r_count <= c_CNT_ONE;
                    end
                end
                default: r_count <= c_CNT_EMPTY;
            endcase
        end
    end

`ifdef BITWISE_LOGIC_PIPE_ZERO_FLAG_EN
    logic r_head_zero;
    logic r_tail_zero;
    logic w_result_zero;

    assign w_result_zero = (w_result == '0);
    assign out_zero      = r_head_zero;

    // Zero flags shadow the data entries move-for-move
    always_ff @(posedge clock) begin
        if (reset) begin
            r_head_zero <= 1'b0;
            r_tail_zero <= 1'b0;
        end else begin
            case (r_count)
                c_CNT_EMPTY: begin
                    if (w_accept) r_head_zero <= w_result_zero;
                end
                c_CNT_ONE: begin
                    if (w_accept && w_pop) r_head_zero <= w_result_zero;
                    else if (w_accept)     r_tail_zero <= w_result_zero;
                end
                c_CNT_FULL: begin
                    if (w_pop) r_head_zero <= r_tail_zero;
                end
                default: ;
            endcase
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bitwise_logic_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitwise_logic_pipe
// Brief    : Self-checking bench for bitwise_logic_pipe (WIDTH=16). Directed
//            scenarios plus a randomized run against a queue-based reference
//            model that derives each result from per-op truth tables.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bitwise_logic_pipe;

    localparam int WIDTH = 16;

    logic             clock;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
`ifdef BITWISE_LOGIC_PIPE_ZERO_FLAG_EN
    logic             out_zero;
`endif

    int n_checks;
    int n_errors;

    // Reference model: ordered queue of pending results
    logic [WIDTH-1:0] m_q[$];
    // Truth table per op, indexed by {a_bit, b_bit}
    logic [3:0]       m_tt[8];

    bitwise_logic_pipe #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef BITWISE_LOGIC_PIPE_ZERO_FLAG_EN
        .out_zero  (out_zero),
`endif
        .out       (out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [WIDTH-1:0] ref_result(input logic [2:0] f_op,
                                                   input logic [WIDTH-1:0] f_a,
                                                   input logic [WIDTH-1:0] f_b);
        logic [WIDTH-1:0] r;
        logic [3:0]       tt;
        tt = m_tt[f_op];
        for (int i = 0; i < WIDTH; i++) r[i] = tt[{f_a[i], f_b[i]}];
        return r;
    endfunction

    // Advance one clock; the model sees the same inputs the DUT samples
    task automatic tick();
        bit acc;
        bit pp;
        logic [WIDTH-1:0] res;
        @(posedge clock);
        if (reset) begin
            m_q.delete();
        end else begin
            acc = in_valid && (m_q.size() < 2);
            pp  = (m_q.size() > 0) && out_ready;
            if (acc) res = ref_result(op, a, b);
            if (pp) void'(m_q.pop_front());
            if (acc) m_q.push_back(res);
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        op = 3'd7; a = 16'hAAAA; b = 16'h5555;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
            n_checks++;
            if (out !== 16'h0000) begin n_errors++; $display("FAIL reset_out got %h want 0000", out); end
            n_checks++;
            if (in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        end
        reset = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_all_ops();
        logic [WIDTH-1:0] exp_seq[8];
        exp_seq = '{16'h0F0F, 16'hF000, 16'hFFF0, 16'h0FF0,
                    16'h0FFF, 16'h000F, 16'hF00F, 16'hF0F0};
        out_ready = 1'b1; a = 16'hF0F0; b = 16'hFF00;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; op = 3'(k);
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out !== exp_seq[k] || m_q.size() != 1 || m_q[0] !== exp_seq[k]) begin
                n_errors++;
                $display("FAIL all_ops op=%0d got valid=%b out=%h want valid=1 out=%h", k, out_valid, out, exp_seq[k]);
            end
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL all_ops_drain got valid=%b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; op = 3'd1; a = 16'hFFFF;
        b = 16'h0001; tick();
        b = 16'h0002; tick();
        b = 16'h0003;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out !== 16'h0001) begin
                n_errors++;
                $display("FAIL bp_full cyc=%0d got in_ready=%b valid=%b out=%h want 0 1 0001", c, in_ready, out_valid, out);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (out !== 16'h0001) begin n_errors++; $display("FAIL bp_first got %h want 0001", out); end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out !== 16'h0002 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_second got valid=%b out=%h in_ready=%b want 1 0002 1", out_valid, out, in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out !== 16'h0003) begin
            n_errors++;
            $display("FAIL bp_third got valid=%b out=%h want 1 0003", out_valid, out);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_drain got valid=%b want 0", out_valid); end
    endtask

    task automatic test_push_pop();
        out_ready = 1'b0; in_valid = 1'b1; op = 3'd7; a = 16'h5555; b = 16'h0000;
        tick();
        out_ready = 1'b1; op = 3'd0; a = 16'h1234;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out !== 16'hEDCB || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL push_pop got valid=%b out=%h in_ready=%b want 1 edcb 1", out_valid, out, in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL push_pop_drain got valid=%b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; op = 3'd2; a = 16'h00F0; b = 16'h0F00;
        tick(); tick();
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_prefill got in_ready=%b valid=%b want 0 1", in_ready, out_valid);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (out_valid !== 1'b0) begin n_errors++; $display("FAIL mid_reset cyc=%0d got valid=%b want 0", c, out_valid); end
            tick();
        end
    endtask

    task automatic test_random();
        int rnd_err;
        rnd_err = 0;
        for (int c = 0; c < 400; c++) begin
            reset     = ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid) begin
                op = 3'($urandom_range(0, 7));
                a  = 16'($urandom);
                b  = 16'($urandom);
            end else begin
                op = 'x; a = 'x; b = 'x;
            end
            #1;
            n_checks++;
            if (in_ready !== (!reset && m_q.size() < 2) ||
                out_valid !== (m_q.size() != 0) ||
                (m_q.size() != 0 && out !== m_q[0])) begin
                n_errors++;
                if (rnd_err < 10)
                    $display("FAIL random cyc=%0d got in_ready=%b valid=%b out=%h want depth=%0d head=%h",
                             c, in_ready, out_valid, out, m_q.size(), (m_q.size() != 0) ? m_q[0] : 16'h0);
                rnd_err++;
            end
            tick();
        end
        reset = 1'b0; in_valid = 1'b0; op = 3'd0; a = '0; b = '0;
        out_ready = 1'b1;
        tick(); tick();
    endtask

`ifdef BITWISE_LOGIC_PIPE_ZERO_FLAG_EN
    task automatic test_zero_flag();
        out_ready = 1'b1; in_valid = 1'b1; op = 3'd3; a = 16'hABCD; b = 16'hABCD;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out !== 16'h0000 || out_zero !== 1'b1) begin
            n_errors++;
            $display("FAIL zero_set got valid=%b out=%h zero=%b want 1 0000 1", out_valid, out, out_zero);
        end
        op = 3'd2; a = 16'h0000; b = 16'h0001;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out !== 16'h0001 || out_zero !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_clear got out=%h zero=%b want 0001 0", out, out_zero);
        end
        tick();
    endtask
`endif

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_tt[0] = 4'b0011; // NOT a
        m_tt[1] = 4'b1000; // AND
        m_tt[2] = 4'b1110; // OR
        m_tt[3] = 4'b0110; // XOR
        m_tt[4] = 4'b0111; // NAND
        m_tt[5] = 4'b0001; // NOR
        m_tt[6] = 4'b1001; // XNOR
        m_tt[7] = 4'b1100; // PASS a
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'd0; a = '0; b = '0;
        @(negedge clock);
        test_reset();
        test_all_ops();
        test_backpressure();
        test_push_pop();
        test_reset_mid();
        test_random();
`ifdef BITWISE_LOGIC_PIPE_ZERO_FLAG_EN
        test_zero_flag();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
